// File: rtl/prog_lut_pkg.sv
// prog_lut_pkg: shared state encoding and table-width helper for prog_lut_seq.
package prog_lut_pkg;
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

    function automatic int tbl_w(input int k);
        return 1 << k;
    endfunction
endpackage

// File: rtl/lut_mux.sv
// lut_mux: combinational 2^K:1 mux built as a binary tree of 2:1 stages.
module lut_mux
    import prog_lut_pkg::*;
#(
    parameter int K = 2
) (
    input  logic [tbl_w(K)-1:0] tbl,
    input  logic [K-1:0]        sel,
    output logic                y
);
    localparam int N = tbl_w(K);

    // heap layout: node 1 is the root, leaves N..2N-1 hold table entries 0..N-1
    logic [2*N-1:1] w_node;

    assign w_node[2*N-1:N] = tbl;
    assign y = w_node[1];

    for (genvar l = 0; l < K; l++) begin : g_lvl
        for (genvar j = 0; j < (1 << l); j++) begin : g_node
            assign w_node[(1 << l) + j] = sel[K-1-l] ? w_node[2*((1 << l) + j) + 1]
                                                     : w_node[2*((1 << l) + j)];
        end
    end
endmodule

// File: rtl/prog_lut_seq.sv
// prog_lut_seq: runtime-programmable K-input LUT with serially loaded,
// double-buffered truth table and a registered lookup.
module prog_lut_seq
    import prog_lut_pkg::*;
#(
    parameter int                  K          = 2,
    parameter logic [(1<<K)-1:0]   INIT_TABLE = 4'b1001
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [K-1:0] sel,
    input  logic         in_valid,
    output logic         y,
    output logic         y_valid,
    input  logic         cfg_start,
    input  logic         cfg_abort,
    input  logic         cfg_valid,
    input  logic         cfg_bit,
    output logic         cfg_ready,
    output logic         cfg_done,
    output logic         busy
);
    localparam int         N    = tbl_w(K);
    localparam logic [K:0] LAST = (K+1)'(N - 1);

    state_t         r_state;
    logic [N-1:0]   r_active;
    logic [N-1:0]   r_shadow;
    logic [K:0]     r_cnt;
    logic           r_y;
    logic           r_y_valid;
    logic           r_done;
    logic           w_mux;

    lut_mux #(.K(K)) u_mux (
        .tbl (r_active),
        .sel (sel),
        .y   (w_mux)
    );

    assign y         = r_y;
    assign y_valid   = r_y_valid;
    assign cfg_done  = r_done;
    assign busy      = r_state == ST_LOAD;
    assign cfg_ready = r_state == ST_LOAD;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y       <= 1'b0;
            r_y_valid <= 1'b0;
        end else begin
            r_y_valid <= in_valid;
            if (in_valid) r_y <= w_mux;
        end
    end

    // priority in LOAD: abort > restart > bit accept (commit on the last bit)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_RUN;
            r_active <= INIT_TABLE;
            r_shadow <= '0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == ST_RUN) begin
                if (cfg_start) begin
                    r_state  <= ST_LOAD;
                    r_shadow <= '0;
                    r_cnt    <= '0;
                end
            end else if (cfg_abort) begin
                r_state  <= ST_RUN;
                r_shadow <= '0;
                r_cnt    <= '0;
            end else if (cfg_start) begin
                r_shadow <= '0;
                r_cnt    <= '0;
            end else if (cfg_valid) begin
                if (r_cnt == LAST) begin
                    r_active <= {cfg_bit, r_shadow[N-1:1]};
                    r_state  <= ST_RUN;
                    r_shadow <= '0;
                    r_cnt    <= '0;
                    r_done   <= 1'b1;
                end else begin
                    r_shadow <= {cfg_bit, r_shadow[N-1:1]};
                    r_cnt    <= r_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_prog_lut_seq.sv
// tb_prog_lut_seq: directed and randomized checks of prog_lut_seq against a
// queue-based reference model of the table load protocol.
module tb_prog_lut_seq;
    localparam int K = 2;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [K-1:0] sel = '0;
    logic         in_valid = 1'b0;
    logic         cfg_start = 1'b0;
    logic         cfg_abort = 1'b0;
    logic         cfg_valid = 1'b0;
    logic         cfg_bit = 1'b0;
    logic         y, y_valid, cfg_ready, cfg_done, busy;

    int n_err = 0;
    int n_chk = 0;

    logic [N-1:0] m_tbl;
    bit           m_load;
    bit           m_q[$];
    logic         m_y, m_yv, m_done;

    always #5 clk = ~clk;

    prog_lut_seq #(.K(K), .INIT_TABLE(4'b1001)) dut (
        .clk       (clk),
        .rst       (rst),
        .sel       (sel),
        .in_valid  (in_valid),
        .y         (y),
        .y_valid   (y_valid),
        .cfg_start (cfg_start),
        .cfg_abort (cfg_abort),
        .cfg_valid (cfg_valid),
        .cfg_bit   (cfg_bit),
        .cfg_ready (cfg_ready),
        .cfg_done  (cfg_done),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_tbl  = 4'b1001;
        m_load = 0;
        m_q.delete();
        m_y    = 0;
        m_yv   = 0;
        m_done = 0;
    endtask

    // one clock: drive inputs, advance the model over the edge, compare all outputs
    task automatic step(input logic [K-1:0] s, input logic iv, input logic st,
                        input logic ab, input logic cv, input logic cb);
        sel = s; in_valid = iv; cfg_start = st; cfg_abort = ab; cfg_valid = cv; cfg_bit = cb;
        @(posedge clk);
        m_done = 0;
        m_yv   = iv;
        if (iv) m_y = m_tbl[s];
        if (m_load) begin
            if (ab) begin
                m_load = 0;
                m_q.delete();
            end else if (st) begin
                m_q.delete();
            end else if (cv) begin
                m_q.push_back(cb);
                if (m_q.size() == N) begin
                    for (int i = 0; i < N; i++) m_tbl[i] = m_q[i];
                    m_q.delete();
                    m_load = 0;
                    m_done = 1;
                end
            end
        end else if (st) begin
            m_load = 1;
            m_q.delete();
        end
        #1;
        check("y", y, m_y);
        check("y_valid", y_valid, m_yv);
        check("cfg_done", cfg_done, m_done);
        check("busy", busy, m_load);
        check("cfg_ready", cfg_ready, m_load);
    endtask

    task automatic idle();
        step('0, 0, 0, 0, 0, 0);
    endtask

    task automatic sweep(input logic [N-1:0] exp);
        for (int s = 0; s < N; s++) begin
            step(K'(s), 1, 0, 0, 0, 0);
            check("sweep_y", y, exp[s]);
        end
        idle();
        check("sweep_yv_drop", y_valid, 0);
    endtask

    initial begin
        model_reset();
        #3;
        check("rst_y", y, 0);
        check("rst_yv", y_valid, 0);
        check("rst_ready", cfg_ready, 0);
        check("rst_done", cfg_done, 0);
        check("rst_busy", busy, 0);
        #9 rst = 1'b0;

        sweep(4'b1001);

        // load 0110, lookup sel=0 in the commit cycle sees the old table
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 1, 1);
        step(0, 1, 0, 0, 1, 0);
        check("commit_old_tbl", y, 1);
        check("commit_done", cfg_done, 1);
        step(0, 1, 0, 0, 0, 0);
        check("post_commit_new", y, 0);
        check("done_one_shot", cfg_done, 0);
        sweep(4'b0110);

        // abort after two bits, abort wins over a same-cycle bit
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 1, 1);
        check("abort_busy", busy, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1, 1);
        sweep(4'b0110);

        // restart after three bits, then four ones
        step(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0);
        step(0, 0, 1, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 1);
        sweep(4'b1111);

        // async reset mid-load after two bits
        step(0, 0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 1, 0);
        step(2, 1, 0, 0, 1, 0);
        check("pre_rst_y", y, 1);
        #2 rst = 1'b1;
        #1;
        check("async_y", y, 0);
        check("async_yv", y_valid, 0);
        check("async_busy", busy, 0);
        check("async_ready", cfg_ready, 0);
        check("async_done", cfg_done, 0);
        model_reset();
        @(negedge clk) rst = 1'b0;
        sweep(4'b1001);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++)
            step(K'($urandom), 1'($urandom), $urandom_range(0, 15) == 0,
                 $urandom_range(0, 31) == 0, 1'($urandom), 1'($urandom));
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 0, 0);
        sweep(m_tbl);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/prog_lut_seq.md
Name: prog_lut_seq

Overview:
- Parametrised, runtime-programmable K-input lookup table. It generalises the fixed-constant mux-tree function into a serially reloadable truth table.
- Lookups go through a registered 2^K:1 mux.
- The truth table is double-buffered. A new table shifts into a shadow register and commits atomically, so lookups never see a partial table.
- Sits between control logic, which programs the logic function, and datapath consumers of a single-bit result.

Parameters:
- K, 2, number of select inputs; the table holds 2^K entries.
- INIT_TABLE, 4'b1001, table value loaded at reset; the default implements XNOR of sel[1], sel[0]. Width is 2^K.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- sel  input  K  lookup address; sel[K-1] is the MSB.
- in_valid  input  1  lookup request qualifier.
- y  output  1  registered table entry.
- y_valid  output  1  y is valid this cycle.
- cfg_start  input  1  pulse; begins a table load.
- cfg_abort  input  1  pulse; discards an in-progress load.
- cfg_valid  input  1  cfg_bit is valid.
- cfg_bit  input  1  serial table bit.
- cfg_ready  output  1  block accepts cfg_bit this cycle.
- cfg_done  output  1  one-cycle pulse on commit.
- busy  output  1  high while in LOAD.

Behaviour:
- Reset (async, rst=1):
  - active table = INIT_TABLE; shadow = 0; bit counter = 0; state = RUN.
  - y=0, y_valid=0, cfg_ready=0, cfg_done=0, busy=0.
  - Reset asserted mid-load discards the shadow; the active table returns to INIT_TABLE.
- State machine: RUN, LOAD.
  - RUN: cfg_start=1 -> LOAD. Shadow and counter clear at that edge. cfg_valid is ignored in RUN.
  - LOAD: cfg_ready=1, busy=1.
    - Each cycle with cfg_valid & cfg_ready, cfg_bit shifts into the shadow MSB end and the counter increments. After 2^K bits the first bit sent lands at entry 0 (LSB), so bits are sent entry 0 first.
    - The commit cycle is the cycle in which the 2^K-th bit is accepted. On its edge the active table takes {cfg_bit, shadow[2^K-1:1]}, state -> RUN, and cfg_done=1 for exactly the next cycle.
    - cfg_abort=1 -> RUN. Shadow is discarded, active table unchanged, no cfg_done. Abort has priority over the bit accepted in the same cycle.
    - cfg_start=1 in LOAD restarts: counter and shadow clear, state stays LOAD. Restart has priority over cfg_valid and over commit; abort has priority over restart.
- Lookup:
  - Independent of config state; continues during LOAD using the old active table.
  - Latency 1: at the edge where in_valid=1, y <= table[sel] and y_valid <= 1.
  - When in_valid=0, y_valid <= 0 and y holds its last value.
  - A lookup sampled on the commit edge uses the old table. The first lookup using the new table is the one sampled on the edge after commit.
- Width rules:
  - Counter width is K+1 bits and saturates at no point: a commit returns it to 0.
  - sel is always in range (2^K entries), so no out-of-range case exists.

Decomposition:
- Shared package/include prog_lut_pkg:
  - state encoding localparams ST_RUN=1'b0, ST_LOAD=1'b1.
  - helper constant function for table width (1<<K).
- One natural sub-module: lut_mux, a parametrised 2^K:1 combinational mux (generate tree of 2:1 stages), driven by the active table. prog_lut_seq registers its output.

Test Plan:
- Reset, K=2, INIT 4'b1001: drive sel=00,01,10,11 with in_valid=1 on consecutive cycles -> y=1,0,0,1 each one cycle later, y_valid=1; the cycle after in_valid drops, y_valid=0.
- Load 4'b0110 (bits sent 0,1,1,0, entry 0 first) -> cfg_done pulses once on the cycle after the 4th bit and busy falls. A sweep of sel 00..11 afterwards gives y=0,1,1,0 (XOR).
- Lookup sel=00 in the commit cycle -> y=1 (old table). sel=00 on the next cycle -> y=0 (new table).
- Load with 2 bits sent, then cfg_abort -> no cfg_done, busy=0, table still 4'b1001. cfg_valid in RUN has no effect.
- cfg_start after 3 bits, then 4 fresh bits 1,1,1,1 -> table=4'b1111, a single cfg_done; all sel give y=1.
- Assert rst mid-load after 2 bits -> all outputs 0 immediately (async), table back to 4'b1001, state RUN.
